// File: rtl/control_unit_pkg.sv
// ---------------------------------------------------------------------------
// control_unit_pkg
// Shared encodings for the copperv control unit: instruction classes produced
// by the decoder, sequencer state encoding, writeback source selects and the
// PC next-value select. Two helper functions classify instruction types so
// the sequencer and anything else in the core agree on which types write rd.
// ---------------------------------------------------------------------------
package control_unit_pkg;

    localparam int INST_TYPE_WIDTH = 3;

    // Instruction classes from the decoder; code 3'd7 is unassigned and is
    // handled as an illegal instruction.
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 3'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 3'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 3'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 3'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_STORE   = 3'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JAL     = 3'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_AUIPC   = 3'd6;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_FETCH      = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_DECODE     = 3'd3,
        ST_EXEC       = 3'd4,
        ST_MEM        = 3'd5,
        ST_MEM_WAIT   = 3'd6,
        ST_WB         = 3'd7
    } state_e;

    localparam logic [1:0] RD_DIN_ALU = 2'd0;
    localparam logic [1:0] RD_DIN_IMM = 2'd1;
    localparam logic [1:0] RD_DIN_PC4 = 2'd2;

    localparam logic PC_NEXT_PC4 = 1'b0;
    localparam logic PC_NEXT_IMM = 1'b1;

    // True for instruction classes that produce a register-file result.
    function automatic logic writes_rd(input logic [INST_TYPE_WIDTH-1:0] t);
        case (t)
            INST_TYPE_IMM, INST_TYPE_AUIPC, INST_TYPE_INT_IMM,
            INST_TYPE_INT_REG, INST_TYPE_JAL: writes_rd = 1'b1;
            default:                          writes_rd = 1'b0;
        endcase
    endfunction

    // True for every class the sequencer knows how to execute.
    function automatic logic is_known_type(input logic [INST_TYPE_WIDTH-1:0] t);
        case (t)
            INST_TYPE_IMM, INST_TYPE_INT_IMM, INST_TYPE_INT_REG,
            INST_TYPE_BRANCH, INST_TYPE_STORE, INST_TYPE_JAL,
            INST_TYPE_AUIPC: is_known_type = 1'b1;
            default:         is_known_type = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Multi-cycle sequencer for the copperv core. Fetches an instruction over the
// instruction-read bus, then steps it through DECODE, EXEC, an optional
// store (MEM/MEM_WAIT) and WB, where the PC and register file are updated.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   inst_type_i         instruction class from the decoder
//   alu_comp_i          branch condition from the ALU (sampled in EXEC)
//   ir_addr_valid_o     fetch address request    / ir_addr_ready_i accept
//   ir_data_valid_i     fetched instruction present (taken in FETCH_WAIT)
//   inst_fetch_o        one-cycle IR load strobe
//   dw_valid_o          store request            / dw_ready_i accept
//   dw_resp_valid_i     store completion response
//   pc_en_o             PC update strobe (WB)
//   pc_next_sel_o       0 = PC+4, 1 = PC+imm
//   rd_en_o             register-file write strobe (WB)
//   rd_din_sel_o        writeback source (ALU / IMM / PC4)
//   alu_din1_sel_o      0 = rs1, 1 = PC
//   alu_din2_sel_o      0 = rs2, 1 = imm
//   illegal_inst_o      pulse in WB for an unrecognised instruction class
// ---------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_TYPE_WIDTH-1:0] inst_type_i,
    input  logic                       alu_comp_i,
    output logic                       ir_addr_valid_o,
    input  logic                       ir_addr_ready_i,
    input  logic                       ir_data_valid_i,
    output logic                       inst_fetch_o,
    output logic                       dw_valid_o,
    input  logic                       dw_ready_i,
    input  logic                       dw_resp_valid_i,
    output logic                       pc_en_o,
    output logic                       pc_next_sel_o,
    output logic                       rd_en_o,
    output logic [1:0]                 rd_din_sel_o,
    output logic                       alu_din1_sel_o,
    output logic                       alu_din2_sel_o,
    output logic                       illegal_inst_o
);

    state_e state_q, state_d;
    logic   taken_q, taken_d;

    // State and branch-taken registers. Reset is asynchronous so the bus
    // valids, which decode straight from state, drop the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    // Next-state logic. Each wait state only looks at the handshake input it
    // is waiting for, so stray responses in other states are simply ignored.
    // The branch decision is captured in EXEC, the only cycle alu_comp_i is
    // meaningful, and carried to WB in taken_q.
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        case (state_q)
            ST_RESET:      state_d = ST_FETCH;
            ST_FETCH:      if (ir_addr_ready_i) state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: if (ir_data_valid_i) state_d = ST_DECODE;
            ST_DECODE:     state_d = ST_EXEC;
            ST_EXEC: begin
                taken_d = (inst_type_i == INST_TYPE_BRANCH) && alu_comp_i;
                state_d = (inst_type_i == INST_TYPE_STORE) ? ST_MEM : ST_WB;
            end
            ST_MEM:        if (dw_ready_i) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT:   if (dw_resp_valid_i) state_d = ST_WB;
            ST_WB:         state_d = ST_FETCH;
            default:       state_d = ST_RESET;
        endcase
    end

    // Output decode. Valids depend on state only, never on the ready they
    // wait for. Operand selects follow inst_type_i for the whole instruction
    // but are forced to zero in RESET so every output is quiet under reset.
    always_comb begin
        ir_addr_valid_o = (state_q == ST_FETCH);
        inst_fetch_o    = (state_q == ST_FETCH_WAIT) && ir_data_valid_i;
        dw_valid_o      = (state_q == ST_MEM);
        pc_en_o         = 1'b0;
        pc_next_sel_o   = PC_NEXT_PC4;
        rd_en_o         = 1'b0;
        illegal_inst_o  = 1'b0;
        rd_din_sel_o    = RD_DIN_ALU;
        alu_din1_sel_o  = 1'b0;
        alu_din2_sel_o  = 1'b0;

        if (state_q == ST_WB) begin
            pc_en_o        = 1'b1;
            rd_en_o        = writes_rd(inst_type_i);
            illegal_inst_o = !is_known_type(inst_type_i);
            if ((inst_type_i == INST_TYPE_JAL) ||
                ((inst_type_i == INST_TYPE_BRANCH) && taken_q))
                pc_next_sel_o = PC_NEXT_IMM;
        end

        if (state_q != ST_RESET) begin
            case (inst_type_i)
                INST_TYPE_IMM:     rd_din_sel_o = RD_DIN_IMM;
                INST_TYPE_INT_IMM: alu_din2_sel_o = 1'b1;
                INST_TYPE_STORE:   alu_din2_sel_o = 1'b1;
                INST_TYPE_JAL: begin
                    rd_din_sel_o   = RD_DIN_PC4;
                    alu_din1_sel_o = 1'b1;
                    alu_din2_sel_o = 1'b1;
                end
                INST_TYPE_AUIPC: begin
                    alu_din1_sel_o = 1'b1;
                    alu_din2_sel_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Drives instructions through control_unit with a bus model that inserts
// random stalls, pushes the expected writeback outcome of each instruction
// into a queue, and lets an independent monitor pop and compare whenever the
// DUT raises pc_en.
// ---------------------------------------------------------------------------
module tb_control_unit;
    import control_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] inst_type;
    logic       alu_comp;
    logic       ir_addr_valid, ir_addr_ready, ir_data_valid, inst_fetch;
    logic       dw_valid, dw_ready, dw_resp_valid;
    logic       pc_en, pc_next_sel, rd_en;
    logic [1:0] rd_din_sel;
    logic       alu_din1_sel, alu_din2_sel, illegal_inst;

    typedef struct {
        logic       pcSel;
        logic       rdEn;
        logic [1:0] rdDin;
        logic       selKnown;
        logic       din1;
        logic       din2;
        logic       illegal;
        int         wbCycle;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    int   lastWb = -1;

    control_unit dut (
        .clk             (clk),
        .rst             (rst),
        .inst_type_i     (inst_type),
        .alu_comp_i      (alu_comp),
        .ir_addr_valid_o (ir_addr_valid),
        .ir_addr_ready_i (ir_addr_ready),
        .ir_data_valid_i (ir_data_valid),
        .inst_fetch_o    (inst_fetch),
        .dw_valid_o      (dw_valid),
        .dw_ready_i      (dw_ready),
        .dw_resp_valid_i (dw_resp_valid),
        .pc_en_o         (pc_en),
        .pc_next_sel_o   (pc_next_sel),
        .rd_en_o         (rd_en),
        .rd_din_sel_o    (rd_din_sel),
        .alu_din1_sel_o  (alu_din1_sel),
        .alu_din2_sel_o  (alu_din2_sel),
        .illegal_inst_o  (illegal_inst)
    );

    // Free-running clock and a cycle counter used to time writebacks.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    task automatic finishRun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Reference behaviour of one instruction at writeback, from the ISA-level
    // rules: which classes write rd, where the PC goes, operand sources.
    function automatic exp_t refModel(input logic [2:0] t, input bit comp,
                                      input int wbCycle);
        exp_t e;
        bit known;
        known      = (t <= 3'd6);
        e.illegal  = !known;
        e.rdEn     = (t == INST_TYPE_IMM) || (t == INST_TYPE_AUIPC) ||
                     (t == INST_TYPE_INT_IMM) || (t == INST_TYPE_INT_REG) ||
                     (t == INST_TYPE_JAL);
        e.pcSel    = (t == INST_TYPE_JAL) || ((t == INST_TYPE_BRANCH) && comp);
        e.rdDin    = (t == INST_TYPE_IMM) ? RD_DIN_IMM :
                     (t == INST_TYPE_JAL) ? RD_DIN_PC4 : RD_DIN_ALU;
        e.selKnown = (t == INST_TYPE_AUIPC) || (t == INST_TYPE_INT_IMM) ||
                     (t == INST_TYPE_INT_REG) || (t == INST_TYPE_BRANCH);
        e.din1     = (t == INST_TYPE_AUIPC);
        e.din2     = (t == INST_TYPE_AUIPC) || (t == INST_TYPE_INT_IMM);
        e.wbCycle  = wbCycle;
        return e;
    endfunction

    // Monitor: every pc_en pulse is a writeback; pop and compare. Outside
    // writeback, rd_en and illegal_inst must stay low.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (pc_en === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedWb", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("wbCycle", cycle, e.wbCycle);
                        checkOutput("pcNextSel", pc_next_sel, e.pcSel);
                        checkOutput("rdEn", rd_en, e.rdEn);
                        checkOutput("illegalInst", illegal_inst, e.illegal);
                        if (e.rdEn) checkOutput("rdDinSel", rd_din_sel, e.rdDin);
                        if (e.selKnown) begin
                            checkOutput("aluDin1Sel", alu_din1_sel, e.din1);
                            checkOutput("aluDin2Sel", alu_din2_sel, e.din2);
                        end
                    end
                end else begin
                    checkOutput("strobesOutsideWb", {rd_en, illegal_inst}, 0);
                end
            end
        end
    end

    // Walks one instruction through the bus protocol. a/d/s/r are stall
    // cycles on address ready, fetch data, store ready and store response.
    task automatic applyStimulus(input logic [2:0] t, input bit decodeComp,
                                 input bit execComp, input int a, input int d,
                                 input int s, input int r, input bit sameCycleData,
                                 input bit earlyResp, input bit midReset);
        int start;
        int wb;
        int dwHigh;
        bit found;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (ir_addr_valid === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            checkOutput("fetchTimeout", 0, 1);
            finishRun();
        end
        start = cycle;
        if (lastWb >= 0) checkOutput("noBubble", start, lastWb + 1);

        wb = start + 4 + a + d;
        if (t == INST_TYPE_STORE) wb += 2 + s + r;
        if (!midReset)
            expQ.push_back(refModel(t, (t == INST_TYPE_BRANCH) && execComp, wb));

        // FETCH with address-ready stalls
        ir_addr_ready = 1'b0;
        for (int k = 0; k < a; k++) begin
            @(negedge clk);
            checkOutput("addrValidHold", ir_addr_valid, 1);
        end
        ir_addr_ready = 1'b1;
        ir_data_valid = sameCycleData;
        @(negedge clk);
        // FETCH_WAIT
        ir_addr_ready = 1'b0;
        ir_data_valid = 1'b0;
        checkOutput("addrValidDrop", ir_addr_valid, 0);
        for (int k = 0; k < d; k++) @(negedge clk);
        inst_type     = t;
        ir_data_valid = 1'b1;
        #1 checkOutput("instFetch", inst_fetch, 1);
        @(negedge clk);
        // DECODE
        ir_data_valid = 1'b0;
        alu_comp      = decodeComp;
        @(negedge clk);
        // EXEC
        alu_comp = execComp;
        @(negedge clk);
        alu_comp = ~execComp;

        if (t == INST_TYPE_STORE) begin
            if (midReset) begin
                checkOutput("dwValidInMem", dw_valid, 1);
                #2 rst = 1'b1;
                #1 checkOutput("dwValidAsyncDrop", dw_valid, 0);
                checkOutput("outputsInReset",
                            {ir_addr_valid, inst_fetch, dw_valid, pc_en,
                             pc_next_sel, rd_en, rd_din_sel, alu_din1_sel,
                             alu_din2_sel, illegal_inst}, 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                alu_comp = 1'b0;
                #1 checkOutput("resetStateAfterRelease", ir_addr_valid, 0);
                @(negedge clk);
                checkOutput("fetchAfterReset", ir_addr_valid, 1);
                lastWb = -1;
                return;
            end
            dwHigh = 0;
            for (int k = 0; k <= s; k++) begin
                if (dw_valid === 1'b1) dwHigh++;
                dw_ready      = (k == s);
                dw_resp_valid = earlyResp && (k == 0);
                @(negedge clk);
            end
            // MEM_WAIT
            checkOutput("dwValidCycles", dwHigh, s + 1);
            dw_ready      = 1'b0;
            dw_resp_valid = 1'b0;
            checkOutput("dwValidDrop", dw_valid, 0);
            for (int k = 0; k < r; k++) @(negedge clk);
            dw_resp_valid = 1'b1;
            @(negedge clk);
            dw_resp_valid = 1'b0;
        end
        // Now at the writeback cycle
        lastWb = cycle;
    endtask

    initial begin
        #100000;
        checkOutput("globalTimeout", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst           = 1'b1;
        inst_type     = INST_TYPE_INT_REG;
        alu_comp      = 1'b0;
        ir_addr_ready = 1'b1;
        ir_data_valid = 1'b0;
        dw_ready      = 1'b0;
        dw_resp_valid = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("outputsInReset",
                    {ir_addr_valid, inst_fetch, dw_valid, pc_en, pc_next_sel,
                     rd_en, rd_din_sel, alu_din1_sel, alu_din2_sel,
                     illegal_inst}, 0);
        rst           = 1'b0;
        ir_addr_ready = 1'b0;
        #1 checkOutput("noFetchAtRelease", ir_addr_valid, 0);
        @(negedge clk);
        checkOutput("fetchOneCycleAfterRelease", ir_addr_valid, 1);

        // Directed cases
        applyStimulus(INST_TYPE_INT_REG, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(INST_TYPE_BRANCH,  0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(INST_TYPE_BRANCH,  1, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(INST_TYPE_STORE,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(INST_TYPE_STORE,   0, 0, 0, 1, 4, 2, 0, 1, 0);
        applyStimulus(INST_TYPE_JAL,     0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(3'd7,              0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(INST_TYPE_STORE,   0, 0, 0, 0, 3, 0, 0, 0, 1);
        applyStimulus(INST_TYPE_IMM,     0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomised instruction stream with random bus stalls
        for (int n = 0; n < 80; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 0);
        finishRun();
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the copperv core. It drives instruction fetch over the instruction-read bus and steps each instruction through decode, execute, optional store, and writeback. It consumes `inst_type` from `idecoder` and the branch-compare flag from the ALU. It produces the PC, register-file, IR-load and ALU-operand controls, plus the data-write bus handshake.

## Interface
- No parameters; all widths and encodings come from `copperv_h.v` macros.
- Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_type`  in  `INST_TYPE_WIDTH`  decoded class from `idecoder`; stable from DECODE until the next `inst_fetch`.
- `alu_comp`  in  1  branch-condition result from the ALU; valid in EXEC.
- `ir_addr_valid`  out  1  fetch-address request.
- `ir_addr_ready`  in  1  bus accepts the fetch address.
- `ir_data_valid`  in  1  fetched instruction present on the bus.
- `inst_fetch`  out  1  one-cycle IR load strobe.
- `dw_valid`  out  1  data-write (store) request.
- `dw_ready`  in  1  bus accepts the store.
- `dw_resp_valid`  in  1  store completion response.
- `pc_en`  out  1  PC update strobe.
- `pc_next_sel`  out  1  0 = PC+4; 1 = PC+imm.
- `rd_en`  out  1  register-file write strobe.
- `rd_din_sel`  out  2  writeback source: `RD_DIN_ALU`, `RD_DIN_IMM`, or `RD_DIN_PC4`.
- `alu_din1_sel`  out  1  0 = rs1; 1 = PC.
- `alu_din2_sel`  out  1  0 = rs2; 1 = imm.
- `illegal_inst`  out  1  one-cycle pulse in WB for an unrecognised `inst_type`.

## Operation
- **States:** RESET, FETCH, FETCH_WAIT, DECODE, EXEC, MEM, MEM_WAIT, WB; state is registered.
- **RESET:** advances unconditionally to FETCH on the first clock after `rst` deasserts.
- **FETCH:** `ir_addr_valid`=1.
  - Moves to FETCH_WAIT on `ir_addr_valid && ir_addr_ready`.
- **FETCH_WAIT:** `ir_addr_valid`=0.
  - On `ir_data_valid`: `inst_fetch`=1 for that cycle, then DECODE.
- **DECODE:** one cycle; the decoder and register-file reads settle. Always goes to EXEC.
- **EXEC:** one cycle.
  - `taken_q` <= `alu_comp` when `inst_type`=BRANCH, else 0.
  - `INST_TYPE_STORE` goes to MEM; every other type goes to WB.
- **MEM:** `dw_valid`=1 until `dw_ready`, then MEM_WAIT.
- **MEM_WAIT:** waits for `dw_resp_valid`, then WB.
- **WB:** one cycle with `pc_en`=1, then FETCH.
  - `pc_next_sel`=1 for JAL, and for BRANCH when `taken_q`=1; otherwise 0.
  - `rd_en`=1 for IMM (LUI), AUIPC, INT_IMM, INT_REG and JAL.
  - `rd_en`=0 for BRANCH, STORE and unknown types.
- **Operand selects:** combinational from `inst_type`, held for the whole instruction. `rd_din_sel`: INT_IMM/INT_REG/AUIPC → ALU; IMM → IMM; JAL → PC4.
  - AUIPC: `alu_din1_sel`=1, `alu_din2_sel`=1.
  - INT_IMM: `alu_din1_sel`=0, `alu_din2_sel`=1.
  - INT_REG and BRANCH: both selects 0.
- **Unknown `inst_type`:** treated as a NOP (PC+4, no write), with `illegal_inst`=1 in WB.
- **Ignored inputs:**
  - `ir_data_valid` outside FETCH_WAIT.
  - `dw_ready` outside MEM.
  - `dw_resp_valid` outside MEM_WAIT.
  - `alu_comp` outside EXEC.

## Timing
- **Reset values:** state=RESET, `taken_q`=0, all strobes and valids 0, all selects 0. Every output is 0 while `rst`=1.
- **Reset mid-operation:** asserting `rst` in any state drops `ir_addr_valid`/`dw_valid` asynchronously; the outstanding bus response is discarded. A new fetch starts from RESET.
- **Valid/ready rules:** valids never drop before their ready arrives. Valids never depend combinationally on the ready they wait for.
- **Latency with zero-wait bus (ready and response in the cycle after request):**
  - Non-store instruction: 5 cycles, FETCH→WB.
  - Store: 7 cycles.
  - Each bus stall cycle adds one cycle.
- **Back-to-back fetch:** WB to the next FETCH has no bubble beyond WB itself.
- **Same-cycle response:** `ir_data_valid` in the same cycle as the address handshake is not accepted. Data is only taken in FETCH_WAIT.

## Structure
- **Shared header `copperv_h.v`:** add the state encodings (3 bits), `RD_DIN_ALU`=0, `RD_DIN_IMM`=1, `RD_DIN_PC4`=2, and `PC_NEXT_PC4`/`PC_NEXT_IMM`. Reuse the existing `INST_TYPE_*`.
- **Implementation:** single module with a registered state and `taken_q`, a combinational next-state block, and a combinational output block. No sub-module is needed.

## Test plan
- **Reset:** hold `rst` 3 cycles with `ir_addr_ready`=1 → all outputs 0. First `ir_addr_valid`=1 appears exactly 1 cycle after release.
- **INT_REG, zero-wait bus:** `inst_fetch` at cycle 2 → `rd_en`=1 and `pc_en`=1 with `pc_next_sel`=0, both in cycle 5 only.
- **BRANCH with `alu_comp`=1 in EXEC:** WB has `pc_next_sel`=1 and `rd_en`=0. The same instruction with `alu_comp`=1 in DECODE but 0 in EXEC gives `pc_next_sel`=0.
- **STORE with `dw_ready` delayed 4 cycles:** `dw_valid` stays high for 5 cycles. `dw_resp_valid` pulsed early in MEM is ignored, and WB follows only the response seen in MEM_WAIT.
- **JAL:** `rd_din_sel`=`RD_DIN_PC4`, `rd_en`=1 and `pc_next_sel`=1 in WB. Unknown `inst_type` gives `illegal_inst`=1, `rd_en`=0 and `pc_next_sel`=0.
- **Reset mid-MEM:** assert `rst` while `dw_valid`=1 → `dw_valid`=0 the same cycle. After release the sequence restarts at FETCH.
